// File: rtl/uart_txrx.sv
// Full-duplex UART: independent TX and RX FSMs on one clock, with a two-flop rxd synchroniser.
// Define UART_TXRX_PARITY_EN to add an even-parity bit after the data bits in both directions.
module uart_txrx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CP,
  input  logic                 RST,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  // state | meaning
  // IDLE  | waiting for tx_en / falling edge on line
  // START | start bit (RX: half-bit to centre sample)
  // DATA  | payload bits, LSB first
  // PARITY| even parity bit (parity build only)
  // STOP  | stop bit(s); RX samples the first only
  // DONE  | RX: report result one cycle after stop sample
  // WAIT_HIGH | RX: line held low after bad stop (break)

  localparam int TX_CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int RX_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [TX_CNT_W-1:0] TX_BIT_LAST  = TX_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TX_CNT_W-1:0] TX_STOP_LAST = TX_CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [RX_CNT_W-1:0] RX_BIT_LAST  = RX_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [RX_CNT_W-1:0] RX_HALF_LAST = RX_CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [BIT_W-1:0]    LAST_BIT     = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_DONE      = 3'd5;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd6;

`ifdef UART_TXRX_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] RX_PARITY = 3'd3;
`endif

  logic [2:0]           r_tx_state;
  logic [TX_CNT_W-1:0]  r_tx_cnt;
  logic [BIT_W-1:0]     r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_txd;
  logic                 r_tx_busy;
  logic                 r_tx_done;
`ifdef UART_TXRX_PARITY_EN
  logic                 r_tx_par;
`endif

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_en) begin
            r_tx_shift <= tx_data;
`ifdef UART_TXRX_PARITY_EN
            r_tx_par   <= ^tx_data;
`endif
            r_txd      <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= TX_BIT_LAST;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_txd      <= r_tx_shift[0];
            r_tx_bit   <= '0;
            r_tx_cnt   <= TX_BIT_LAST;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            if (r_tx_bit == LAST_BIT) begin
`ifdef UART_TXRX_PARITY_EN
              r_txd      <= r_tx_par;
              r_tx_cnt   <= TX_BIT_LAST;
              r_tx_state <= TX_PARITY;
`else
              r_txd      <= 1'b1;
              r_tx_cnt   <= TX_STOP_LAST;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_cnt   <= TX_BIT_LAST;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
`ifdef UART_TXRX_PARITY_EN
        TX_PARITY: begin
          if (r_tx_cnt == '0) begin
            r_txd      <= 1'b1;
            r_tx_cnt   <= TX_STOP_LAST;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_done  <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;

  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 r_rx_prev;
  logic [2:0]           r_rx_state;
  logic [RX_CNT_W-1:0]  r_rx_cnt;
  logic [BIT_W-1:0]     r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_stop;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_ferr;
  logic                 w_rx_fall;
`ifdef UART_TXRX_PARITY_EN
  logic                 r_rx_par_bad;
  logic                 r_rx_perr;
`endif

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;

  // Synchroniser and edge-detect history reset to the idle (high) line level.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_stop    <= 1'b1;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_ferr    <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_rx_perr    <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
      r_rx_perr  <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= RX_HALF_LAST;
            r_rx_state <= RX_START;
`ifdef UART_TXRX_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bit   <= '0;
              r_rx_cnt   <= RX_BIT_LAST;
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_cnt   <= RX_BIT_LAST;
            if (r_rx_bit == LAST_BIT) begin
`ifdef UART_TXRX_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
`ifdef UART_TXRX_PARITY_EN
        RX_PARITY: begin
          if (r_rx_cnt == '0) begin
            r_rx_par_bad <= r_rx_s2 ^ (^r_rx_shift);
            r_rx_cnt     <= RX_BIT_LAST;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_stop  <= r_rx_s2;
            r_rx_state <= RX_DONE;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DONE: begin
          if (!r_rx_stop) begin
            r_rx_ferr  <= 1'b1;
            r_rx_state <= RX_WAIT_HIGH;
`ifdef UART_TXRX_PARITY_EN
          end else if (r_rx_par_bad) begin
            r_rx_perr  <= 1'b1;
            r_rx_state <= RX_IDLE;
`endif
          end else begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_rx_state <= RX_IDLE;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_ferr;
`ifdef UART_TXRX_PARITY_EN
  assign rx_parity_err = r_rx_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: default instance in loopback, plus a 5-bit/4-clk/2-stop instance.
module tb_uart_txrx;

`ifdef UART_TXRX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CPB      = 16;
  localparam int NB       = 10 + PAR;
  localparam int LAT_DONE = NB * CPB;
  localparam int LAT_RX   = 2 + CPB / 2 + (9 + PAR) * CPB + 1;
  localparam int SM_NB       = 8 + PAR;
  localparam int SM_LAT_DONE = SM_NB * 4;
  localparam int SM_LAT_RX   = 2 + 2 + (6 + PAR) * 4 + 1;

  logic CP, rst;
  logic tx_en, tx_busy, tx_done, txd, rxd, rx_valid, rx_ferr, rx_perr;
  logic [7:0] tx_data, rx_data;
  logic loop_en, flip, rxd_drv;

  logic sm_tx_en, sm_tx_busy, sm_tx_done, sm_txd, sm_rx_valid, sm_rx_ferr, sm_rx_perr;
  logic [4:0] sm_tx_data, sm_rx_data;

  assign rxd = loop_en ? (txd ^ flip) : rxd_drv;

  uart_txrx u_dut (
    .CP(CP), .RST(rst), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_ferr), .rx_parity_err(rx_perr)
  );

  uart_txrx #(.DATA_BITS(5), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_small (
    .CP(CP), .RST(rst), .tx_en(sm_tx_en), .tx_data(sm_tx_data), .tx_busy(sm_tx_busy),
    .tx_done(sm_tx_done), .txd(sm_txd), .rxd(sm_txd), .rx_data(sm_rx_data),
    .rx_valid(sm_rx_valid), .rx_frame_err(sm_rx_ferr), .rx_parity_err(sm_rx_perr)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  int n_done = 0, n_valid = 0, n_ferr = 0, n_perr = 0;
  int t_done[16], t_valid[16];
  int t_perr = 0;
  logic [7:0] rx_log[16];
  int sm_n_done = 0, sm_n_valid = 0, sm_t_done = 0, sm_t_valid = 0;
  logic [4:0] sm_last = '0;

  always @(negedge CP) begin
    if (tx_done) begin t_done[n_done & 15] <= cyc; n_done <= n_done + 1; end
    if (rx_valid) begin
      t_valid[n_valid & 15] <= cyc; rx_log[n_valid & 15] <= rx_data; n_valid <= n_valid + 1;
    end
    if (rx_ferr) n_ferr <= n_ferr + 1;
    if (rx_perr) begin n_perr <= n_perr + 1; t_perr <= cyc; end
    if (sm_tx_done) begin sm_n_done <= sm_n_done + 1; sm_t_done <= cyc; end
    if (sm_rx_valid) begin sm_n_valid <= sm_n_valid + 1; sm_t_valid <= cyc; sm_last <= sm_rx_data; end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic p);
    logic [15:0] f;
    f = '0;
    f[8:1] = d;
    if (PAR == 1) begin f[9] = p; f[10] = 1'b1; end
    else f[9] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, output int acc);
    @(negedge CP); tx_data = d; tx_en = 1'b1;
    @(negedge CP); acc = cyc; tx_en = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] d, input logic [7:0] exp_rx,
                             input logic exp_par);
    int acc, nd0, nv0, k;
    logic [15:0] bits;
    logic busy_mid, busy_end;
    nd0 = n_done; nv0 = n_valid; bits = '0; busy_mid = 1'b0; busy_end = 1'b1;
    send(d, acc);
    k = 0;
    while (k < LAT_DONE + 4) begin
      @(negedge CP);
      k = cyc - acc;
      if (k % CPB == CPB / 2 && k / CPB < NB) bits[k / CPB] = txd;
      if (k == LAT_DONE - 1) busy_mid = tx_busy;
      if (k == LAT_DONE) busy_end = tx_busy;
    end
    chk({nm, " txd_bits"}, 32'(bits), 32'(frame_bits(d, exp_par)));
    chk({nm, " done_cnt"}, n_done - nd0, 1);
    chk({nm, " done_lat"}, t_done[nd0 & 15] - acc, LAT_DONE);
    chk({nm, " busy_mid"}, 32'(busy_mid), 1);
    chk({nm, " busy_end"}, 32'(busy_end), 0);
    chk({nm, " valid_cnt"}, n_valid - nv0, 1);
    chk({nm, " valid_lat"}, t_valid[nv0 & 15] - acc, LAT_RX);
    chk({nm, " rx_data"}, 32'(rx_log[nv0 & 15]), 32'(exp_rx));
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] f;
    int nbits;
    f = '0;
    f[8:1] = d;
    if (PAR == 1) begin f[9] = p; f[10] = stop; nbits = 11; end
    else begin f[9] = stop; nbits = 10; end
    for (int i = 0; i < nbits; i++) begin
      rxd_drv = f[i];
      repeat (CPB) @(negedge CP);
    end
    if (!stop) repeat (2 * CPB) @(negedge CP);
    rxd_drv = 1'b1;
    repeat (40) @(negedge CP);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
    logic       exp_par;
  } vec_t;
  vec_t vt[6];

  initial begin
    int acc, nd0, nv0, nf0, np0, k;
    logic [15:0] sbits;
    logic gap_txd, gap_busy, nxt_txd, nxt_busy;

    vt[0] = '{8'h42, 8'h42, 1'b0};
    vt[1] = '{8'hA5, 8'hA5, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'hFF, 1'b0};
    vt[4] = '{8'h07, 8'h07, 1'b1};
    vt[5] = '{8'h01, 8'h01, 1'b1};

    rst = 1'b1; tx_en = 1'b0; tx_data = '0; loop_en = 1'b1; flip = 1'b0; rxd_drv = 1'b1;
    sm_tx_en = 1'b0; sm_tx_data = '0;
    repeat (3) @(negedge CP);
    chk("rst txd", 32'(txd), 1);
    chk("rst tx_busy", 32'(tx_busy), 0);
    chk("rst tx_done", 32'(tx_done), 0);
    chk("rst rx_data", 32'(rx_data), 0);
    chk("rst rx_valid", 32'(rx_valid), 0);
    chk("rst rx_ferr", 32'(rx_ferr), 0);
    chk("rst rx_perr", 32'(rx_perr), 0);
    chk("rst sm_txd", 32'(sm_txd), 1);
    rst = 1'b0;
    repeat (4) @(negedge CP);

    for (int i = 0; i < 6; i++)
      check_frame($sformatf("vec%0d", i), vt[i].data, vt[i].exp_rx, vt[i].exp_par);

    // Back-to-back: tx_en held high through the whole first frame, data changed while busy.
    nd0 = n_done; nv0 = n_valid;
    @(negedge CP); tx_data = 8'h42; tx_en = 1'b1;
    @(negedge CP); acc = cyc; tx_data = 8'h23;
    gap_txd = 1'b0; gap_busy = 1'b1; nxt_txd = 1'b1; nxt_busy = 1'b0;
    k = 0;
    while (k < 2 * LAT_DONE + 6) begin
      @(negedge CP);
      k = cyc - acc;
      if (k == LAT_DONE) begin gap_txd = txd; gap_busy = tx_busy; end
      if (k == LAT_DONE + 1) begin nxt_txd = txd; nxt_busy = tx_busy; tx_en = 1'b0; end
    end
    chk("b2b gap_txd", 32'(gap_txd), 1);
    chk("b2b gap_busy", 32'(gap_busy), 0);
    chk("b2b next_txd", 32'(nxt_txd), 0);
    chk("b2b next_busy", 32'(nxt_busy), 1);
    chk("b2b done_cnt", n_done - nd0, 2);
    chk("b2b done2_lat", t_done[(nd0 + 1) & 15] - acc, 2 * LAT_DONE + 1);
    chk("b2b valid_cnt", n_valid - nv0, 2);
    chk("b2b rx0", 32'(rx_log[nv0 & 15]), 32'h42);
    chk("b2b rx1", 32'(rx_log[(nv0 + 1) & 15]), 32'h23);
    chk("b2b valid2_lat", t_valid[(nv0 + 1) & 15] - acc, LAT_DONE + 1 + LAT_RX);

    // Single-cycle low glitch on the line.
    loop_en = 1'b0;
    repeat (4) @(negedge CP);
    nv0 = n_valid; nf0 = n_ferr;
    rxd_drv = 1'b0;
    @(negedge CP); rxd_drv = 1'b1;
    repeat (40) @(negedge CP);
    chk("glitch valid", n_valid - nv0, 0);
    chk("glitch ferr", n_ferr - nf0, 0);

    // Bad stop bit, then a good frame.
    nv0 = n_valid; nf0 = n_ferr;
    drive_rx(8'h99, 1'b0, 1'b0);
    chk("ferr cnt", n_ferr - nf0, 1);
    chk("ferr valid", n_valid - nv0, 0);
    chk("ferr rx_hold", 32'(rx_data), 32'h23);
    drive_rx(8'hA5, 1'b0, 1'b1);
    chk("post_ferr valid", n_valid - nv0, 1);
    chk("post_ferr rx", 32'(rx_data), 32'hA5);
    chk("post_ferr ferr", n_ferr - nf0, 1);

    // Reset in the middle of data bit 3 of an all-zero frame.
    loop_en = 1'b1;
    repeat (4) @(negedge CP);
    nd0 = n_done; nv0 = n_valid;
    send(8'h00, acc);
    k = 0;
    while (k < 5 * CPB - 10) begin
      @(negedge CP);
      k = cyc - acc;
    end
    chk("pre_rst txd", 32'(txd), 0);
    rst = 1'b1;
    #1;
    chk("rst_mid txd", 32'(txd), 1);
    chk("rst_mid busy", 32'(tx_busy), 0);
    repeat (2) @(negedge CP);
    rst = 1'b0;
    repeat (LAT_DONE + 10) @(negedge CP);
    chk("rst_mid done", n_done - nd0, 0);
    chk("rst_mid valid", n_valid - nv0, 0);
    check_frame("after_rst", 8'h3C, 8'h3C, 1'b0);

`ifdef UART_TXRX_PARITY_EN
    // Invert the parity bit on its way back to rxd.
    nv0 = n_valid; np0 = n_perr; nf0 = n_ferr;
    send(8'h07, acc);
    k = 0;
    while (k < LAT_DONE + 4) begin
      @(negedge CP);
      k = cyc - acc;
      flip = (k >= 9 * CPB && k < 10 * CPB);
    end
    flip = 1'b0;
    chk("perr cnt", n_perr - np0, 1);
    chk("perr lat", t_perr - acc, LAT_RX);
    chk("perr valid", n_valid - nv0, 0);
    chk("perr ferr", n_ferr - nf0, 0);
    chk("perr rx_hold", 32'(rx_data), 32'h3C);
    loop_en = 1'b0;
    np0 = n_perr; nv0 = n_valid;
    drive_rx(8'hA5, 1'b1, 1'b1);
    chk("perr drv cnt", n_perr - np0, 1);
    chk("perr drv valid", n_valid - nv0, 0);
    loop_en = 1'b1;
`endif

    // Small instance: 5 data bits, 4 clocks per bit, 2 stop bits.
    nd0 = sm_n_done; nv0 = sm_n_valid; sbits = '0;
    @(negedge CP); sm_tx_data = 5'h15; sm_tx_en = 1'b1;
    @(negedge CP); acc = cyc; sm_tx_en = 1'b0;
    k = 0;
    while (k < SM_LAT_DONE + 4) begin
      @(negedge CP);
      k = cyc - acc;
      if (k % 4 == 2 && k / 4 < SM_NB) sbits[k / 4] = sm_txd;
    end
`ifdef UART_TXRX_PARITY_EN
    chk("sm txd_bits", 32'(sbits), 32'h1EA);
`else
    chk("sm txd_bits", 32'(sbits), 32'h0EA);
`endif
    chk("sm done_cnt", sm_n_done - nd0, 1);
    chk("sm done_lat", sm_t_done - acc, SM_LAT_DONE);
    chk("sm valid_cnt", sm_n_valid - nv0, 1);
    chk("sm valid_lat", sm_t_valid - acc, SM_LAT_RX);
    chk("sm rx_data", 32'(sm_last), 32'h15);
    chk("sm rx_ferr", 32'(sm_rx_ferr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
